dac_output_hpf_stream: RTL and testbench

Self-timed successor to the fixed-slot DAC output path. It accepts offset-binary amplifier samples on a valid strobe and runs each one through optional software-reference subtraction, a one-pole high-pass filter, a noise dead-zone, 2^gain scaling and a hysteretic threshold comparator. It then drives an AD5662-class SPI DAC with its own bit-rate generator, so it no longer depends on main_state/channel slot decoding. It sits between the per-channel sample demux and the board DAC pins, one instance per DAC.

---
 rtl/dac_stream_pkg.sv | 36 +++
 rtl/dac_spi_shifter.sv | 134 +++++++++++++
 rtl/dac_output_hpf_stream.sv | 169 ++++++++++++++++
 tb/tb_dac_output_hpf_stream.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_stream_pkg.sv
// Shared types and arithmetic helpers for the streaming DAC output path.
// Helpers operate on 64-bit signed values; callers cast the result to their width.
package dac_stream_pkg;

    typedef enum logic [2:0] {
        SH_IDLE,
        SH_LOAD,
        SH_HIGH,
        SH_LOW,
        SH_GAP
    } sh_state_t;

    function automatic logic [63:0] midscale(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [63:0] shift_sat(input logic signed [63:0] v,
                                                     input logic [2:0] sh, input int w);
        return sat_signed(v <<< sh, w);
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// One-deep pending word slot feeding an AD5662-style SPI frame generator.
// Frame: LOAD, then per bit HIGH/LOW of CLK_DIV cycles each, then a one-cycle GAP.
module dac_spi_shifter
    import dac_stream_pkg::*;
#(
    parameter int DW       = 16,
    parameter int PAD_BITS = 8,
    parameter int CLK_DIV  = 1
) (
    input  logic          dataclk,
    input  logic          reset,
    input  logic          word_valid,
    input  logic [DW-1:0] word,
    input  logic          overrun_clear,
    output logic          dac_sync,
    output logic          dac_sclk,
    output logic          dac_din,
    output logic          busy,
    output logic          overrun
);

    localparam int FW    = PAD_BITS + DW;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FW + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);

    sh_state_t         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [FW-1:0]     shreg_q, shreg_d;
    logic [DW-1:0]     pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              overrun_q, overrun_d;
    logic              take;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        take        = (state_q == SH_LOAD);

        case (state_q)
            SH_IDLE: begin
                if (pend_full_q) begin
                    state_d = SH_LOAD;
                end
            end
            SH_LOAD: begin
                // Zero-extension supplies the leading pad bits.
                shreg_d = FW'(pend_q);
                bit_d   = '0;
                div_d   = '0;
                state_d = SH_HIGH;
            end
            SH_HIGH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = SH_LOW;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SH_LOW: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = SH_GAP;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shreg_d = {shreg_q[FW-2:0], 1'b0};
                        state_d = SH_HIGH;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SH_GAP: begin
                state_d = SH_IDLE;
            end
            default: begin
                state_d = SH_IDLE;
            end
        endcase

        // A write in the same cycle as the take refills the freed slot without loss.
        if (take) begin
            pend_full_d = 1'b0;
        end
        if (word_valid) begin
            pend_d      = word;
            pend_full_d = 1'b1;
        end
        if (overrun_clear) begin
            overrun_d = 1'b0;
        end
        if (word_valid && pend_full_q && !take) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            state_q     <= SH_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        dac_sync = !((state_q == SH_LOAD) || (state_q == SH_HIGH) || (state_q == SH_LOW));
        dac_sclk = (state_q == SH_HIGH);
        dac_din  = ((state_q == SH_HIGH) || (state_q == SH_LOW)) ? shreg_q[FW-1] : 1'b0;
        busy     = (state_q != SH_IDLE);
        overrun  = overrun_q;
    end

endmodule

// File: rtl/dac_output_hpf_stream.sv
// Sample-strobed DAC path: reference subtract, one-pole HPF, dead-zone, gain,
// hysteretic threshold comparator, then a self-timed SPI DAC shifter.
module dac_output_hpf_stream
    import dac_stream_pkg::*;
#(
    parameter int DW       = 16,
    parameter int PAD_BITS = 8,
    parameter int CLK_DIV  = 1,
    parameter int COEF_W   = 16
) (
    input  logic              dataclk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DW-1:0]     sample_in,
    input  logic              software_reference_mode,
    input  logic [DW-1:0]     software_reference,
    input  logic              HPF_en,
    input  logic [COEF_W-1:0] HPF_coefficient,
    input  logic [6:0]        noise_suppress,
    input  logic [2:0]        gain,
    input  logic              DAC_en,
    input  logic [DW-1:0]     DAC_thrsh,
    input  logic              DAC_thrsh_pol,
    input  logic [DW-1:0]     DAC_thrsh_hyst,
    input  logic              overrun_clear,
    output logic              DAC_SYNC,
    output logic              DAC_SCLK,
    output logic              DAC_DIN,
    output logic              DAC_thrsh_out,
    output logic              busy,
    output logic              overrun
);

    localparam int SW = 2 * DW;
    localparam int PW = DW + COEF_W + 1;
    localparam logic [DW-1:0] MID = DW'(midscale(DW));

    logic signed [DW-1:0] x_q, x_d, x1_q, x1_d, x2_q, x2_d;
    logic signed [DW-1:0] diff_q, diff_d, diff2_q, diff2_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [SW-1:0] hpf_q, hpf_d;
    logic                 v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic                 thr_q, thr_d;

    logic signed [DW-1:0] smp_s, ref_s, y, scaled;
    logic signed [63:0]   dz, nz;
    logic [DW-1:0]        y_off, word;
    logic [DW:0]          thr_lo, thr_hi;
    logic                 word_valid;

    // S0 converts offset-binary to two's complement; S1/S2 form the filter error and product.
    always_comb begin
        smp_s = {~sample_in[DW-1], sample_in[DW-2:0]};
        ref_s = {~software_reference[DW-1], software_reference[DW-2:0]};
        v0_d  = sample_valid;
        x_d   = x_q;
        if (sample_valid) begin
            x_d = software_reference_mode ? DW'(sat_signed(64'(smp_s) - 64'(ref_s), DW)) : smp_s;
        end
        v1_d    = v0_q;
        x1_d    = x_q;
        diff_d  = DW'(sat_signed(64'(x_q) - 64'($signed(hpf_q[SW-1:DW])), DW));
        v2_d    = v1_q;
        x2_d    = x1_q;
        diff2_d = diff_q;
        prod_d  = PW'(diff_q) * PW'($signed({1'b0, HPF_coefficient}));
    end

    // S3: integrate, dead-zone, scale and hand the word to the shifter.
    always_comb begin
        hpf_d = hpf_q;
        if (v2_q) begin
            hpf_d = hpf_q + SW'(prod_q);
        end
        y  = HPF_en ? diff2_q : x2_q;
        nz = {53'd0, noise_suppress, 4'd0};
        dz = 64'(y);
        if (dz > 64'sd0) begin
            dz = dz - nz;
            if (dz < 64'sd0) begin
                dz = 64'sd0;
            end
        end else if (dz < 64'sd0) begin
            dz = dz + nz;
            if (dz > 64'sd0) begin
                dz = 64'sd0;
            end
        end
        scaled     = DW'(shift_sat(dz, gain, DW));
        word       = DAC_en ? {~scaled[DW-1], scaled[DW-2:0]} : MID;
        word_valid = v2_q;
    end

    // Comparator works on the unfiltered-by-dead-zone value in offset form.
    always_comb begin
        y_off  = {~y[DW-1], y[DW-2:0]};
        thr_lo = (DAC_thrsh >= DAC_thrsh_hyst) ? {1'b0, DAC_thrsh - DAC_thrsh_hyst} : '0;
        thr_hi = {1'b0, DAC_thrsh} + {1'b0, DAC_thrsh_hyst};
        if (thr_hi[DW]) begin
            thr_hi = {1'b0, {DW{1'b1}}};
        end
        thr_d = thr_q;
        if (!DAC_en) begin
            thr_d = 1'b0;
        end else if (v2_q) begin
            if (DAC_thrsh_pol) begin
                if (y_off >= DAC_thrsh) begin
                    thr_d = 1'b1;
                end else if ({1'b0, y_off} < thr_lo) begin
                    thr_d = 1'b0;
                end
            end else begin
                if (y_off <= DAC_thrsh) begin
                    thr_d = 1'b1;
                end else if ({1'b0, y_off} > thr_hi) begin
                    thr_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge dataclk) begin
        if (reset) begin
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            x_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            diff_q  <= '0;
            diff2_q <= '0;
            prod_q  <= '0;
            hpf_q   <= '0;
            thr_q   <= 1'b0;
        end else begin
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            x_q     <= x_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            diff_q  <= diff_d;
            diff2_q <= diff2_d;
            prod_q  <= prod_d;
            hpf_q   <= hpf_d;
            thr_q   <= thr_d;
        end
    end

    assign DAC_thrsh_out = thr_q;

    dac_spi_shifter #(
        .DW       (DW),
        .PAD_BITS (PAD_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_shifter (
        .dataclk       (dataclk),
        .reset         (reset),
        .word_valid    (word_valid),
        .word          (word),
        .overrun_clear (overrun_clear),
        .dac_sync      (DAC_SYNC),
        .dac_sclk      (DAC_SCLK),
        .dac_din       (DAC_DIN),
        .busy          (busy),
        .overrun       (overrun)
    );

endmodule

// File: tb/tb_dac_output_hpf_stream.sv
// Self-checking bench: SPI frame decoder, vector table, corner sequences and a
// randomized run against an arithmetic reference model.
module tb_dac_output_hpf_stream;

    localparam int DW = 16;
    localparam int PAD = 8;
    localparam int FW = PAD + DW;

    logic        dataclk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        software_reference_mode = 1'b0;
    logic [15:0] software_reference = '0;
    logic        HPF_en = 1'b0;
    logic [15:0] HPF_coefficient = '0;
    logic [6:0]  noise_suppress = '0;
    logic [2:0]  gain = '0;
    logic        DAC_en = 1'b1;
    logic [15:0] DAC_thrsh = 16'h9000;
    logic        DAC_thrsh_pol = 1'b1;
    logic [15:0] DAC_thrsh_hyst = 16'h0100;
    logic        overrun_clear = 1'b0;
    logic        DAC_SYNC, DAC_SCLK, DAC_DIN, DAC_thrsh_out, busy, overrun;

    always #5 dataclk = ~dataclk;

    dac_output_hpf_stream #(.DW(16), .PAD_BITS(8), .CLK_DIV(1), .COEF_W(16)) dut (
        .dataclk(dataclk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
        .software_reference_mode(software_reference_mode), .software_reference(software_reference),
        .HPF_en(HPF_en), .HPF_coefficient(HPF_coefficient), .noise_suppress(noise_suppress),
        .gain(gain), .DAC_en(DAC_en), .DAC_thrsh(DAC_thrsh), .DAC_thrsh_pol(DAC_thrsh_pol),
        .DAC_thrsh_hyst(DAC_thrsh_hyst), .overrun_clear(overrun_clear), .DAC_SYNC(DAC_SYNC),
        .DAC_SCLK(DAC_SCLK), .DAC_DIN(DAC_DIN), .DAC_thrsh_out(DAC_thrsh_out), .busy(busy),
        .overrun(overrun)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // SPI frame decoder: bits taken at each SCLK fall while SYNC is low.
    logic [FW-1:0] frames[$];
    logic [FW-1:0] mon_sh = '0;
    int  mon_bits = 0, sync_run = 0, busy_run = 0, last_sync_len = 0, last_busy_len = 0;
    logic prev_sclk = 1'b0, prev_sync = 1'b1, prev_busy = 1'b0;

    always @(negedge dataclk) begin
        if (reset) begin
            mon_bits = 0;
            sync_run = 0;
            busy_run = 0;
        end else begin
            if (!DAC_SYNC) sync_run++;
            if (busy) busy_run++;
            if (prev_sclk && !DAC_SCLK && !DAC_SYNC) begin
                mon_sh = {mon_sh[FW-2:0], DAC_DIN};
                mon_bits++;
            end
            if (!prev_sync && DAC_SYNC) begin
                if (mon_bits == FW) frames.push_back(mon_sh);
                last_sync_len = sync_run;
                sync_run = 0;
                mon_bits = 0;
            end
            if (prev_busy && !busy) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
        end
        prev_sclk = DAC_SCLK;
        prev_sync = DAC_SYNC;
        prev_busy = busy;
    end

    task automatic do_reset();
        @(posedge dataclk);
        #1 reset = 1'b1;
        repeat (3) @(posedge dataclk);
        #1 reset = 1'b0;
        frames.delete();
    endtask

    task automatic send(input logic [15:0] v);
        @(posedge dataclk);
        #1 sample_in = v;
        sample_valid = 1'b1;
        @(posedge dataclk);
        #1 sample_valid = 1'b0;
    endtask

    task automatic expect_word(input string name, input logic [15:0] exp);
        logic [FW-1:0] f;
        bit ok;
        ok = 1'b0;
        f = '0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (frames.size() > 0) begin
                f = frames.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge dataclk);
            end
        end
        if (ok) begin
            check(name, 32'(f), {16'd0, 8'd0, exp});
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no SPI frame within 400 cycles, expected word 0x%0h", name, exp);
        end
    endtask

    task automatic apply(input string name, input logic [15:0] v, input logic [15:0] w, input logic t);
        send(v);
        expect_word({name, "_word"}, w);
        check({name, "_thr"}, 32'(DAC_thrsh_out), 32'(t));
    endtask

    typedef struct {
        logic [15:0] smp;
        logic        rm;
        logic [15:0] rf;
        logic [6:0]  ns;
        logic [2:0]  g;
        logic        en;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[14];

    // Reference model: plain integer arithmetic on the signed sample value.
    int   m_state = 0;
    logic m_thr = 1'b0;

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_step(input logic [15:0] smp, output logic [15:0] w);
        int s, r, x, d, y, t, nzw, yo, th, hy, lo, hi;
        s = int'(smp) - 32768;
        r = int'(software_reference) - 32768;
        x = software_reference_mode ? clamp16(longint'(s) - longint'(r)) : s;
        d = clamp16(longint'(x) - longint'(m_state >>> 16));
        m_state = m_state + d * int'(HPF_coefficient);
        y = HPF_en ? d : x;
        nzw = int'(noise_suppress) * 16;
        t = y;
        if (y > 0) t = (y - nzw > 0) ? y - nzw : 0;
        else if (y < 0) t = (y + nzw < 0) ? y + nzw : 0;
        t = clamp16(longint'(t) * (longint'(1) << gain));
        w = DAC_en ? 16'(t + 32768) : 16'h8000;
        yo = y + 32768;
        th = int'(DAC_thrsh);
        hy = int'(DAC_thrsh_hyst);
        lo = (th >= hy) ? th - hy : 0;
        hi = (th + hy > 65535) ? 65535 : th + hy;
        if (DAC_thrsh_pol) begin
            if (yo >= th) m_thr = 1'b1;
            else if (yo < lo) m_thr = 1'b0;
        end else begin
            if (yo <= th) m_thr = 1'b1;
            else if (yo > hi) m_thr = 1'b0;
        end
        if (!DAC_en) m_thr = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sync_cyc;
        logic [9:0] thr_hist;
        logic [15:0] w, smp;

        vecs[0]  = '{16'h9234, 1'b0, 16'h0000, 7'd0, 3'd0, 1'b1, 16'h9234};
        vecs[1]  = '{16'h9000, 1'b0, 16'h0000, 7'd0, 3'd3, 1'b1, 16'hFFFF};
        vecs[2]  = '{16'h7F00, 1'b0, 16'h0000, 7'd0, 3'd3, 1'b1, 16'h7800};
        vecs[3]  = '{16'h8014, 1'b0, 16'h0000, 7'd2, 3'd0, 1'b1, 16'h8000};
        vecs[4]  = '{16'h8064, 1'b0, 16'h0000, 7'd2, 3'd0, 1'b1, 16'h8044};
        vecs[5]  = '{16'h7F9C, 1'b0, 16'h0000, 7'd2, 3'd0, 1'b1, 16'h7FBC};
        vecs[6]  = '{16'h9000, 1'b1, 16'h8800, 7'd0, 3'd0, 1'b1, 16'h8800};
        vecs[7]  = '{16'hFFFF, 1'b1, 16'h0000, 7'd0, 3'd0, 1'b1, 16'hFFFF};
        vecs[8]  = '{16'h0000, 1'b1, 16'hFFFF, 7'd0, 3'd0, 1'b1, 16'h0000};
        vecs[9]  = '{16'h7000, 1'b0, 16'h0000, 7'd0, 3'd7, 1'b1, 16'h0000};
        vecs[10] = '{16'h9234, 1'b0, 16'h0000, 7'd0, 3'd0, 1'b0, 16'h8000};
        vecs[11] = '{16'h8001, 1'b0, 16'h0000, 7'd0, 3'd7, 1'b1, 16'h8080};
        vecs[12] = '{16'h8010, 1'b0, 16'h0000, 7'd1, 3'd0, 1'b1, 16'h8000};
        vecs[13] = '{16'h7FF0, 1'b0, 16'h0000, 7'd1, 3'd0, 1'b1, 16'h8000};

        do_reset();
        @(negedge dataclk);
        check("rst_sync", 32'(DAC_SYNC), 32'd1);
        check("rst_sclk", 32'(DAC_SCLK), 32'd0);
        check("rst_din", 32'(DAC_DIN), 32'd0);
        check("rst_thr", 32'(DAC_thrsh_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Latency: SYNC low in cycle 5, comparator changes in cycle 4.
        sync_cyc = -1;
        thr_hist = '0;
        @(posedge dataclk);
        #1 sample_in = 16'h9234;
        sample_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge dataclk);
            thr_hist[k] = DAC_thrsh_out;
            if (!DAC_SYNC && sync_cyc < 0) sync_cyc = k;
            if (k == 0) begin
                @(posedge dataclk);
                #1 sample_valid = 1'b0;
            end
        end
        check("sync_low_cycle", 32'(sync_cyc), 32'd5);
        check("thr_cycle3", 32'(thr_hist[3]), 32'd0);
        check("thr_cycle4", 32'(thr_hist[4]), 32'd1);
        expect_word("frame_9234", 16'h9234);
        repeat (3) @(negedge dataclk);
        check("sync_low_len", 32'(last_sync_len), 32'd49);
        check("busy_len", 32'(last_busy_len), 32'd50);
        check("busy_after_gap", 32'(busy), 32'd0);

        // Comparator, trip above with hysteresis band [0x8F00, 0x9000).
        apply("cmp_9000", 16'h9000, 16'h9000, 1'b1);
        apply("cmp_8F80_hold1", 16'h8F80, 16'h8F80, 1'b1);
        apply("cmp_8EFF", 16'h8EFF, 16'h8EFF, 1'b0);
        apply("cmp_8F80_hold0", 16'h8F80, 16'h8F80, 1'b0);
        apply("cmp_9000_again", 16'h9000, 16'h9000, 1'b1);
        DAC_en = 1'b0;
        apply("cmp_dac_off", 16'h9500, 16'h8000, 1'b0);
        DAC_en = 1'b1;
        DAC_thrsh_pol = 1'b0;
        DAC_thrsh = 16'h7000;
        apply("cmp_pol0_7000", 16'h7000, 16'h7000, 1'b1);
        apply("cmp_pol0_7080", 16'h7080, 16'h7080, 1'b1);
        apply("cmp_pol0_7101", 16'h7101, 16'h7101, 1'b0);
        apply("cmp_pol0_7100", 16'h7100, 16'h7100, 1'b0);

        for (int i = 0; i < 14; i++) begin
            software_reference_mode = vecs[i].rm;
            software_reference = vecs[i].rf;
            noise_suppress = vecs[i].ns;
            gain = vecs[i].g;
            DAC_en = vecs[i].en;
            send(vecs[i].smp);
            expect_word($sformatf("vec%0d", i), vecs[i].exp);
        end
        software_reference_mode = 1'b0;
        noise_suppress = '0;
        gain = '0;
        DAC_en = 1'b1;

        // HPF step response with B = 0.5.
        do_reset();
        HPF_en = 1'b1;
        HPF_coefficient = 16'h8000;
        send(16'hC000);
        expect_word("hpf_1", 16'hC000);
        send(16'hC000);
        expect_word("hpf_2", 16'hA000);
        send(16'hC000);
        expect_word("hpf_3", 16'h9000);
        HPF_en = 1'b0;

        // Three samples inside one frame: the middle one is overwritten.
        send(16'h8100);
        repeat (10) @(posedge dataclk);
        send(16'h8200);
        repeat (5) @(negedge dataclk);
        check("overrun_before", 32'(overrun), 32'd0);
        send(16'h8300);
        repeat (6) @(negedge dataclk);
        check("overrun_set", 32'(overrun), 32'd1);
        expect_word("ovr_first", 16'h8100);
        expect_word("ovr_third", 16'h8300);
        repeat (60) @(negedge dataclk);
        check("ovr_no_extra", 32'(frames.size()), 32'd0);
        check("overrun_sticky", 32'(overrun), 32'd1);
        @(posedge dataclk);
        #1 overrun_clear = 1'b1;
        @(posedge dataclk);
        #1 overrun_clear = 1'b0;
        @(negedge dataclk);
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Reset in the middle of a frame.
        send(16'h8555);
        repeat (20) @(posedge dataclk);
        #1 reset = 1'b1;
        @(posedge dataclk);
        @(negedge dataclk);
        check("abort_sync", 32'(DAC_SYNC), 32'd1);
        check("abort_sclk", 32'(DAC_SCLK), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge dataclk);
        #1 reset = 1'b0;
        frames.delete();
        repeat (60) @(negedge dataclk);
        check("abort_no_frame", 32'(frames.size()), 32'd0);

        // Randomized run against the model.
        do_reset();
        m_state = 0;
        m_thr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            software_reference_mode = 1'($urandom_range(0, 1));
            software_reference = 16'($urandom);
            HPF_en = 1'($urandom_range(0, 1));
            HPF_coefficient = 16'($urandom);
            noise_suppress = 7'($urandom_range(0, 15));
            gain = 3'($urandom_range(0, 7));
            DAC_en = ($urandom_range(0, 9) != 0);
            DAC_thrsh_pol = 1'($urandom_range(0, 1));
            DAC_thrsh = 16'($urandom);
            DAC_thrsh_hyst = 16'($urandom_range(0, 16'h2000));
            if ($urandom_range(0, 1) == 1) smp = 16'($urandom);
            else smp = 16'(32'h7800 + $urandom_range(0, 16'h1000));
            model_step(smp, w);
            send(smp);
            expect_word($sformatf("rnd%0d_word", i), w);
            check($sformatf("rnd%0d_thr", i), 32'(DAC_thrsh_out), 32'(m_thr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
